activation_backprop_layer_2: RTL

//  Backward-pass partner of the layer-2 activation unit: for each output neuron computes

---
 rtl/activation_backprop_layer_2.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/activation_backprop_layer_2.sv
// activation_backprop_layer_2: layer-2 backward pass, delta = (a - t) * f'(z).
// It has a 2-stage valid/ready pipeline, counts a frame of NUM_NEURONS and sums the frame's deltas.
// Ports:
//   clk, reset_n (async active-low)
//   start (pulse; only acted on in IDLE), done (pulse; the frame is complete)
//   in_valid/in_ready with z_in, a_in, t_in (signed)
//   out_valid/out_ready with delta_out (signed)
//   bias_grad_sum: signed sum of the frame's deltas. It is held stable after the frame ends.
// Optional build macro DELTA_SATURATE_EN: the delta and the sum saturate.
// Without it, the delta and the sum wrap.
module activation_backprop_layer_2 #(
  parameter int voltage_size    = 63,
  parameter int activation_size = 131,
  parameter int delta_size      = 32,
  parameter int acc_size        = 40,
  parameter int NUM_NEURONS     = 10
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              start,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic signed [voltage_size-1:0]    z_in,
  input  logic signed [activation_size-1:0] a_in,
  input  logic signed [activation_size-1:0] t_in,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic signed [delta_size-1:0]      delta_out,
  output logic signed [acc_size-1:0]        bias_grad_sum,
  output logic                              done
);

  localparam int EW = activation_size + 1;
  localparam int CW = $clog2(NUM_NEURONS + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]              state;
  logic [CW-1:0]           in_cnt;
  logic [CW-1:0]           out_cnt;
  logic                    stall;
  logic                    accept;
  logic                    out_hs;

  logic                    s1_valid;
  logic signed [EW-1:0]    s1_err;
  logic signed [3:0]       s1_der;

  logic signed [EW-1:0]    err_nx;
  logic signed [3:0]       der_nx;
  logic [3:0]              zl;
  logic signed [delta_size-1:0] delta_nx;
  logic signed [acc_size-1:0]   sum_nx;

  assign stall    = out_valid && !out_ready;
  assign in_ready = (state == RUN) &&
                    (in_cnt < CW'(NUM_NEURONS)) && !stall;
  assign accept   = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;
  assign done     = (state == DONE);

  assign err_nx = {a_in[activation_size-1], a_in}
                - {t_in[activation_size-1], t_in};

  // Only the low nibble of z matters inside -2..2.
  assign zl = z_in[3:0];

  always_comb begin
    der_nx = '0;
    unique case (1'b1)
      (z_in >= -2) && (z_in < 0):
        der_nx = 4'sd1 + $signed({zl[2:0], 1'b0});
      (z_in >= 0) && (z_in <= 2):
        der_nx = 4'sd1 - $signed({zl[2:0], 1'b0});
      default:
        der_nx = '0;
    endcase
  end

`ifdef DELTA_SATURATE_EN
  localparam int PW = EW + 4;
  logic signed [PW-1:0]       prod;
  logic                       prod_fits;
  logic signed [acc_size:0]   acc_wide;

  assign prod = s1_err * s1_der;
  // The product fits when every bit above the delta sign bit is a copy of the sign.
  assign prod_fits = (&prod[PW-1:delta_size-1]) ||
                     !(|prod[PW-1:delta_size-1]);

  always_comb begin
    delta_nx = prod[delta_size-1:0];
    if (!prod_fits)
      delta_nx = prod[PW-1] ?
        {1'b1, {(delta_size-1){1'b0}}} :
        {1'b0, {(delta_size-1){1'b1}}};
  end

  assign acc_wide =
    {bias_grad_sum[acc_size-1], bias_grad_sum} +
    {{(acc_size-delta_size+1){delta_out[delta_size-1]}},
     delta_out};

  always_comb begin
    sum_nx = acc_wide[acc_size-1:0];
    if (acc_wide[acc_size] != acc_wide[acc_size-1])
      sum_nx = acc_wide[acc_size] ?
        {1'b1, {(acc_size-1){1'b0}}} :
        {1'b0, {(acc_size-1){1'b1}}};
  end
`else
  assign delta_nx = delta_size'(s1_err * s1_der);
  assign sum_nx = bias_grad_sum +
    {{(acc_size-delta_size){delta_out[delta_size-1]}},
     delta_out};
`endif

  // A downstream stall holds both stages in place.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid  <= 1'b0;
      s1_err    <= '0;
      s1_der    <= '0;
      out_valid <= 1'b0;
      delta_out <= '0;
    end else if (!stall) begin
      s1_valid <= accept;
      if (accept) begin
        s1_err <= err_nx;
        s1_der <= der_nx;
      end
      out_valid <= s1_valid;
      if (s1_valid)
        delta_out <= delta_nx;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      in_cnt        <= '0;
      out_cnt       <= '0;
      bias_grad_sum <= '0;
    end else begin
      if (out_hs) begin
        out_cnt       <= out_cnt + CW'(1);
        bias_grad_sum <= sum_nx;
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            state         <= RUN;
            in_cnt        <= '0;
            out_cnt       <= '0;
            bias_grad_sum <= '0;
          end
        end
        RUN: begin
          if (accept)
            in_cnt <= in_cnt + CW'(1);
          if (in_cnt == CW'(NUM_NEURONS))
            state <= DRAIN;
        end
        DRAIN: begin
          if (out_cnt == CW'(NUM_NEURONS))
            state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
